// File: rtl/level_meter.sv
// Multi-channel audio level meter: per-channel peak-follow level with timed
// exponential decay, peak-hold marker and sticky clip flag. The selected
// channel drives a log-scale (~6 dB per LED) thermometer bar.
module level_meter #(
  parameter int CHANNELS          = 2,
  parameter int DATA_BITS         = 24,
  parameter int LED_BITS          = 14,
  parameter int DECAY_PERIOD_BITS = 16,
  parameter int DECAY_SHIFT       = 3,
  parameter int HOLD_TICKS        = 64,
  parameter logic [DATA_BITS-1:0] CLIP_LEVEL = 24'h7F0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic [CHANNELS*DATA_BITS-1:0] sample_data,
  input  logic                          mode,
  input  logic [$clog2(CHANNELS):0]     ch_sel,
  input  logic                          clip_clr,
  output logic [CHANNELS*DATA_BITS-1:0] levels,
  output logic [CHANNELS-1:0]           clip,
  output logic [LED_BITS-1:0]           leds
);

  localparam int SEL_W  = $clog2(CHANNELS) + 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  // Magnitude of a signed sample; the most-negative code saturates to full scale.
  function automatic logic [DATA_BITS-1:0] abs_sat(input logic signed [DATA_BITS-1:0] s);
    logic signed [DATA_BITS-1:0] min_v;
    min_v = {1'b1, {(DATA_BITS-1){1'b0}}};
    if (s == min_v)               return {1'b0, {(DATA_BITS-1){1'b1}}};
    else if (s[DATA_BITS-1])      return -s;
    else                          return s;
  endfunction

  // One decay step: subtract level/2**DECAY_SHIFT, or 1 once that rounds to zero.
  function automatic logic [DATA_BITS-1:0] decay_step(input logic [DATA_BITS-1:0] l);
    logic [DATA_BITS-1:0] d;
    d = l >> DECAY_SHIFT;
    if (d != '0)      return l - d;
    else if (l != '0) return l - DATA_BITS'(1);
    else              return '0;
  endfunction

  // LED threshold i, one octave (~6 dB) per LED with the top LED at half scale.
  function automatic logic [DATA_BITS-1:0] thr(input int i);
    return DATA_BITS'(1) << (DATA_BITS - 1 - LED_BITS + i);
  endfunction

  logic [DATA_BITS-1:0]         abs_p1_q   [CHANNELS];
  logic [DATA_BITS-1:0]         abs_p1_d   [CHANNELS];
  logic                         vld_p1_q, vld_p1_d;
  logic [DATA_BITS-1:0]         level_q    [CHANNELS];
  logic [DATA_BITS-1:0]         level_d    [CHANNELS];
  logic [DATA_BITS-1:0]         peak_q     [CHANNELS];
  logic [DATA_BITS-1:0]         peak_d     [CHANNELS];
  logic [HOLD_W-1:0]            hold_q     [CHANNELS];
  logic [HOLD_W-1:0]            hold_d     [CHANNELS];
  logic [CHANNELS-1:0]          clip_q, clip_d;
  logic [DECAY_PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic                         tick;
  logic [LED_BITS-1:0]          leds_q, leds_d;
  logic [DATA_BITS-1:0]         sel_level, sel_peak;
  logic                         sel_ok;
  logic [LED_BITS-1:0]          bar, mark;

  // Stage 1 boundary: sample magnitudes captured one cycle after the strobe.
  always_comb begin
    vld_p1_d = sample_valid;
    for (int c = 0; c < CHANNELS; c++) begin
      abs_p1_d[c] = abs_sat(sample_data[c*DATA_BITS +: DATA_BITS]);
    end
  end

  // Free-running decay timer; tick fires on the cycle the counter wraps to zero.
  always_comb begin
    cnt_d = cnt_q + DECAY_PERIOD_BITS'(1);
    tick  = &cnt_q;
  end

  // Stage 2 boundary: level attack/decay, peak hold and sticky clip per channel.
  always_comb begin
    clip_d = clip_q;
    for (int c = 0; c < CHANNELS; c++) begin
      level_d[c] = level_q[c];
      peak_d[c]  = peak_q[c];
      hold_d[c]  = hold_q[c];
      // An attacking sample exceeds the undecayed level, hence also the decayed one.
      if (vld_p1_q && (abs_p1_q[c] > level_q[c])) level_d[c] = abs_p1_q[c];
      else if (tick)                               level_d[c] = decay_step(level_q[c]);
      if (vld_p1_q && (abs_p1_q[c] >= peak_q[c])) begin
        peak_d[c] = abs_p1_q[c];
        hold_d[c] = HOLD_W'(HOLD_TICKS);
      end else if (tick) begin
        if (hold_q[c] != '0) hold_d[c] = hold_q[c] - HOLD_W'(1);
        else                 peak_d[c] = level_q[c];
      end
      if (vld_p1_q && (abs_p1_q[c] >= CLIP_LEVEL)) clip_d[c] = 1'b1;
      else if (clip_clr)                           clip_d[c] = 1'b0;
    end
  end

  // Stage 3 boundary: thermometer bar plus optional peak marker for the selected channel.
  always_comb begin
    sel_level = '0;
    sel_peak  = '0;
    sel_ok    = 1'b0;
    bar       = '0;
    mark      = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel == SEL_W'(c)) begin
        sel_level = level_q[c];
        sel_peak  = peak_q[c];
        sel_ok    = 1'b1;
      end
    end
    for (int i = 0; i < LED_BITS; i++) begin
      bar[i] = (sel_level >= thr(i));
      if (sel_peak >= thr(i)) begin
        mark    = '0;
        mark[i] = 1'b1;
      end
    end
    leds_d = sel_ok ? (bar | (mode ? mark : '0)) : '0;
  end

  // State registers; reset clears the meter and discards any in-flight sample.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1_q <= 1'b0;
      cnt_q    <= '0;
      clip_q   <= '0;
      leds_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        abs_p1_q[c] <= '0;
        level_q[c]  <= '0;
        peak_q[c]   <= '0;
        hold_q[c]   <= '0;
      end
    end else begin
      vld_p1_q <= vld_p1_d;
      cnt_q    <= cnt_d;
      clip_q   <= clip_d;
      leds_q   <= leds_d;
      for (int c = 0; c < CHANNELS; c++) begin
        abs_p1_q[c] <= abs_p1_d[c];
        level_q[c]  <= level_d[c];
        peak_q[c]   <= peak_d[c];
        hold_q[c]   <= hold_d[c];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_levels
    assign levels[c*DATA_BITS +: DATA_BITS] = level_q[c];
  end

  assign clip = clip_q;
  assign leds = leds_q;

endmodule

// File: tb/tb_level_meter.sv
// Directed bench for level_meter: table of single-sample vectors plus
// hand-written sequences for decay, peak hold, clip clear and mid-stream reset.
module tb_level_meter;

  localparam int PERIOD = 16;  // 2**DECAY_PERIOD_BITS used below

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [47:0] sample_data;
  logic        mode;
  logic [1:0]  ch_sel;
  logic        clip_clr;
  logic [47:0] levels;
  logic [1:0]  clip;
  logic [13:0] leds;

  int errors = 0;
  int checks = 0;
  int ph     = 0;  // bench copy of the decay timer phase

  level_meter #(
    .CHANNELS(2), .DATA_BITS(24), .LED_BITS(14), .DECAY_PERIOD_BITS(4),
    .DECAY_SHIFT(3), .HOLD_TICKS(2), .CLIP_LEVEL(24'h7F0000)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .mode(mode), .ch_sel(ch_sel), .clip_clr(clip_clr),
    .levels(levels), .clip(clip), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] d0, d1;
    logic [1:0]  sel;
    logic        md;
    logic [23:0] l0, l1;
    logic [1:0]  clp;
    logic [13:0] led;
  } vec_t;

  vec_t vt[10];

  task automatic cyc();
    @(posedge clk);
    if (!rst) ph = 0;
    else      ph = (ph + 1) % PERIOD;
    #1;
  endtask

  // Advance to the next cycle whose timer phase is p (always at least one cycle).
  task automatic align(input int p);
    int n;
    n = (p - ph + PERIOD) % PERIOD;
    if (n == 0) n = PERIOD;
    repeat (n) cyc();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lvl(input int c);
    return {8'h00, levels[c*24 +: 24]};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic send(input logic [23:0] d0, input logic [23:0] d1);
    sample_data  = {d1, d0};
    sample_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b0; sample_valid = 1'b1; sample_data = {24'h7FFFFF, 24'h800000};
    mode = 1'b1; ch_sel = 2'd0; clip_clr = 1'b0;

    // Reset state, with strobes and full-scale data present during reset.
    cyc(); cyc();
    chk("rst_level0", lvl(0), 32'h0);
    chk("rst_level1", lvl(1), 32'h0);
    chk("rst_clip", {30'h0, clip}, 32'h0);
    chk("rst_leds", {18'h0, leds}, 32'h0);
    sample_valid = 1'b0;
    rst = 1'b1;

    // Table: one sample after reset, levels/clip at +2, leds at +3.
    vt[0] = '{24'h000400, 24'h000000, 2'd0, 1'b0, 24'h000400, 24'h000000, 2'b00, 14'h0003};
    vt[1] = '{24'h000000, 24'h800000, 2'd1, 1'b0, 24'h000000, 24'h7FFFFF, 2'b10, 14'h3FFF};
    vt[2] = '{24'hFFFC00, 24'h000200, 2'd0, 1'b0, 24'h000400, 24'h000200, 2'b00, 14'h0003};
    vt[3] = '{24'hFFFC00, 24'h000200, 2'd1, 1'b0, 24'h000400, 24'h000200, 2'b00, 14'h0001};
    vt[4] = '{24'h7F0000, 24'h7EFFFF, 2'd0, 1'b0, 24'h7F0000, 24'h7EFFFF, 2'b01, 14'h3FFF};
    vt[5] = '{24'h810000, 24'h810001, 2'd2, 1'b0, 24'h7F0000, 24'h7EFFFF, 2'b01, 14'h0000};
    vt[6] = '{24'h0001FF, 24'h000200, 2'd0, 1'b1, 24'h0001FF, 24'h000200, 2'b00, 14'h0000};
    vt[7] = '{24'h0003FF, 24'h100000, 2'd1, 1'b1, 24'h0003FF, 24'h100000, 2'b00, 14'h0FFF};
    vt[8] = '{24'h0003FF, 24'h000000, 2'd0, 1'b1, 24'h0003FF, 24'h000000, 2'b00, 14'h0001};
    vt[9] = '{24'h7FFFFF, 24'hFFFFFF, 2'd3, 1'b1, 24'h7FFFFF, 24'h000001, 2'b01, 14'h0000};

    for (int i = 0; i < 10; i++) begin
      ch_sel = vt[i].sel;
      mode   = vt[i].md;
      do_reset();
      send(vt[i].d0, vt[i].d1);
      cyc();
      sample_valid = 1'b0;
      cyc();
      chk($sformatf("vec%0d_level0", i), lvl(0), {8'h0, vt[i].l0});
      chk($sformatf("vec%0d_level1", i), lvl(1), {8'h0, vt[i].l1});
      chk($sformatf("vec%0d_clip", i), {30'h0, clip}, {30'h0, vt[i].clp});
      cyc();
      chk($sformatf("vec%0d_leds", i), {18'h0, leds}, {18'h0, vt[i].led});
    end

    // Decay from full scale, down to zero.
    ch_sel = 2'd0; mode = 1'b0;
    do_reset();
    send(24'h800000, 24'h000000);
    cyc();
    sample_valid = 1'b0;
    cyc();
    chk("decay_start", lvl(0), 32'h007FFFFF);
    align(15);
    chk("decay_before_tick", lvl(0), 32'h007FFFFF);
    cyc();
    chk("decay_tick1", lvl(0), 32'h00700000);
    cyc();
    chk("decay_tick1_leds", {18'h0, leds}, 32'h00003FFF);
    align(0);
    chk("decay_tick2", lvl(0), 32'h00620000);
    for (int n = 0; n < 4000 && lvl(0) != 32'h0; n++) cyc();
    chk("decay_to_zero", lvl(0), 32'h0);
    repeat (40) cyc();
    chk("decay_stays_zero", lvl(0), 32'h0);
    chk("decay_leds_zero", {18'h0, leds}, 32'h0);
    chk("decay_clip_sticky", {30'h0, clip}, 32'h1);

    // Peak hold marker: held for two ticks, then tracks level one tick behind.
    ch_sel = 2'd0; mode = 1'b1;
    do_reset();
    send(24'h400000, 24'h000000);
    cyc();
    send(24'h000400, 24'h000000);
    cyc();
    sample_valid = 1'b0;
    cyc();
    chk("hold_initial_leds", {18'h0, leds}, 32'h00003FFF);
    align(1);
    chk("hold_tick1_level", lvl(0), 32'h00380000);
    chk("hold_tick1_leds", {18'h0, leds}, 32'h00003FFF);
    mode = 1'b0;
    cyc();
    chk("hold_mode0_leds", {18'h0, leds}, 32'h00001FFF);
    mode = 1'b1;
    cyc();
    chk("hold_mode1_leds", {18'h0, leds}, 32'h00003FFF);
    align(1);
    chk("hold_tick2_level", lvl(0), 32'h00310000);
    chk("hold_tick2_leds", {18'h0, leds}, 32'h00003FFF);
    align(1);
    chk("hold_tick3_level", lvl(0), 32'h002AE000);
    chk("hold_tick3_leds", {18'h0, leds}, 32'h00001FFF);
    align(1); align(1); align(1);
    chk("hold_tick6_level", lvl(0), 32'h001CB910);
    chk("hold_tick6_leds", {18'h0, leds}, 32'h00001FFF);
    align(1);
    chk("hold_tick7_leds", {18'h0, leds}, 32'h00000FFF);

    // Clip clear against a simultaneous clipping sample, then alone.
    ch_sel = 2'd1; mode = 1'b0;
    do_reset();
    send(24'h000000, 24'h7F0000);
    cyc();
    sample_valid = 1'b0;
    clip_clr = 1'b1;
    cyc();
    chk("clr_set_wins", {30'h0, clip}, 32'h2);
    cyc();
    chk("clr_alone", {30'h0, clip}, 32'h0);
    chk("clr_level_kept", lvl(1), 32'h007F0000);
    clip_clr = 1'b0;
    send(24'h000000, 24'h810000);
    cyc();
    send(24'h000000, 24'h000010);
    cyc();
    sample_valid = 1'b0;
    cyc(); cyc();
    chk("clip_sticky", {30'h0, clip}, 32'h2);

    // Back-to-back samples, then reset with samples in flight.
    ch_sel = 2'd1; mode = 1'b0;
    do_reset();
    send(24'h001000, 24'h000000);
    cyc();
    send(24'h002000, 24'h000000);
    cyc();
    chk("b2b_1", lvl(0), 32'h00001000);
    send(24'h003000, 24'h000000);
    cyc();
    chk("b2b_2", lvl(0), 32'h00002000);
    send(24'h000000, 24'h200000);
    cyc();
    chk("b2b_3", lvl(0), 32'h00003000);
    sample_valid = 1'b0;
    cyc(); cyc();
    chk("pre_rst_leds", {18'h0, leds}, 32'h00001FFF);
    send(24'h7FFFFF, 24'h800000);
    cyc();
    rst = 1'b0;
    cyc();
    chk("midrst_level0", lvl(0), 32'h0);
    chk("midrst_level1", lvl(1), 32'h0);
    chk("midrst_clip", {30'h0, clip}, 32'h0);
    chk("midrst_leds", {18'h0, leds}, 32'h0);
    rst = 1'b1;
    sample_valid = 1'b0;
    cyc();
    chk("inflight_level0", lvl(0), 32'h0);
    chk("inflight_level1", lvl(1), 32'h0);
    cyc();
    chk("inflight_clip", {30'h0, clip}, 32'h0);
    chk("inflight_leds", {18'h0, leds}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
